// File: rtl/axi_llc_pkg.sv
// Shared LLC types: tag-store request/response records, access mode and flush FSM states.
package axi_llc_pkg;

  localparam int unsigned LlcSetAssoc    = 8;
  localparam int unsigned LlcNumLines    = 256;
  localparam int unsigned LlcTagLength   = 20;
  localparam int unsigned LlcIndexLength = $clog2(LlcNumLines);

  typedef enum logic [1:0] {Bist, Flush, Lookup} llc_mode_e;

  typedef struct packed {
    llc_mode_e                 mode;
    logic [LlcSetAssoc-1:0]    indicator;
    logic [LlcIndexLength-1:0] index;
    logic [LlcTagLength-1:0]   tag;
    logic                      dirty;
  } store_req_t;

  typedef struct packed {
    logic [LlcSetAssoc-1:0]  indicator;
    logic                    hit;
    logic                    evict;
    logic [LlcTagLength-1:0] evict_tag;
  } store_res_t;

  typedef enum logic [2:0] {IDLE, REQ, RESP, WB, DONE} flush_state_e;

endpackage

// File: rtl/axi_llc_flush_way_sel.sv
// Picks the lowest set bit of the pending way mask, as one-hot and as a binary way number.
module axi_llc_flush_way_sel #(
  parameter int unsigned Ways    = 8,
  parameter int unsigned WayIdxW = (Ways > 1) ? $clog2(Ways) : 1
) (
  input  logic [Ways-1:0]    pending_i,
  output logic [Ways-1:0]    onehot_o,
  output logic [WayIdxW-1:0] idx_o
);

  // Scanning downwards lets the lowest set bit be the last one written.
  always_comb begin
    idx_o = '0;
    for (int i = Ways - 1; i >= 0; i--) begin
      if (pending_i[i]) idx_o = i[WayIdxW-1:0];
    end
  end

  assign onehot_o = pending_i & (~pending_i + Ways'(1));

endmodule

// File: rtl/axi_llc_flush_seq.sv
// Flush sequencer: walks every index of each selected way, forwards dirty evictions to write-back.
// Optional AXI_LLC_FLUSH_PERF_EN adds saturating evict/line handshake counters.
module axi_llc_flush_seq
  import axi_llc_pkg::*;
#(
  parameter int unsigned SetAssociativity = LlcSetAssoc,
  parameter int unsigned NumLines         = LlcNumLines,
  parameter int unsigned TagLength        = LlcTagLength
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [SetAssociativity-1:0] flush_mask_i,
  input  logic                        flush_valid_i,
  output logic                        flush_ready_o,
  output store_req_t                  store_req_o,
  output logic                        store_valid_o,
  input  logic                        store_ready_i,
  input  store_res_t                  store_res_i,
  input  logic                        store_res_valid_i,
  output logic                        store_res_ready_o,
  output logic [SetAssociativity-1:0] wb_way_o,
  output logic [$clog2(NumLines)-1:0] wb_index_o,
  output logic [TagLength-1:0]        wb_tag_o,
  output logic                        wb_valid_o,
  input  logic                        wb_ready_i,
  output logic [SetAssociativity-1:0] flushed_o,
  output logic                        flush_done_o,
  input  logic [SetAssociativity-1:0] unflush_i
`ifdef AXI_LLC_FLUSH_PERF_EN
  ,
  output logic [31:0]                 evict_cnt_o,
  output logic [31:0]                 line_cnt_o
`endif
);

  localparam int unsigned IndexLength = $clog2(NumLines);
  localparam int unsigned WayIdxW     = (SetAssociativity > 1) ? $clog2(SetAssociativity) : 1;
  localparam logic [IndexLength-1:0] LastIndex = IndexLength'(NumLines - 1);

  flush_state_e                state_q, state_d;
  logic [SetAssociativity-1:0] pending_q, pending_d;
  logic [SetAssociativity-1:0] flushed_q, flushed_d;
  logic [IndexLength-1:0]      index_q, index_d;
  logic [TagLength-1:0]        evict_tag_q, evict_tag_d;
  logic [SetAssociativity-1:0] way_onehot, set_mask;
  logic [WayIdxW-1:0]          way_idx;
  logic                        advance, accept;

  axi_llc_flush_way_sel #(
    .Ways    (SetAssociativity),
    .WayIdxW (WayIdxW)
  ) i_way_sel (
    .pending_i (pending_q),
    .onehot_o  (way_onehot),
    .idx_o     (way_idx)
  );

  always_comb begin
    state_d           = state_q;
    pending_d         = pending_q;
    index_d           = index_q;
    evict_tag_d       = evict_tag_q;
    set_mask          = '0;
    advance           = 1'b0;
    accept            = 1'b0;
    flush_ready_o     = 1'b0;
    store_valid_o     = 1'b0;
    store_res_ready_o = 1'b0;
    wb_valid_o        = 1'b0;
    flush_done_o      = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Ready is masked during reset so every output reads zero while rst_i is high.
        flush_ready_o = ~rst_i;
        if (flush_valid_i && !rst_i) begin
          accept    = 1'b1;
          pending_d = flush_mask_i & ~flushed_q;
          index_d   = '0;
          state_d   = (|(flush_mask_i & ~flushed_q)) ? REQ : DONE;
        end
      end
      REQ: begin
        store_valid_o = 1'b1;
        if (store_ready_i) state_d = RESP;
      end
      RESP: begin
        store_res_ready_o = 1'b1;
        if (store_res_valid_i) begin
          if (store_res_i.evict) begin
            evict_tag_d = store_res_i.evict_tag;
            state_d     = WB;
          end else begin
            advance = 1'b1;
          end
        end
      end
      WB: begin
        wb_valid_o = 1'b1;
        if (wb_ready_i) advance = 1'b1;
      end
      DONE: begin
        flush_done_o = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (advance) begin
      if (index_q == LastIndex) begin
        set_mask[way_idx] = 1'b1;
        pending_d         = pending_q & ~way_onehot;
        index_d           = '0;
      end else begin
        index_d = index_q + IndexLength'(1);
      end
      state_d = (|pending_d) ? REQ : DONE;
    end

    // A way completing in the same cycle as its unflush stays flushed.
    flushed_d = (flushed_q & ~unflush_i) | set_mask;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      flushed_q   <= '0;
      index_q     <= '0;
      evict_tag_q <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      flushed_q   <= flushed_d;
      index_q     <= index_d;
      evict_tag_q <= evict_tag_d;
    end
  end

  // The current way and index are stable from REQ through WB, so payloads are gated state views.
  always_comb begin
    store_req_o = '0;
    if (state_q == REQ) begin
      store_req_o.mode      = Flush;
      store_req_o.indicator = way_onehot;
      store_req_o.index     = index_q;
    end
  end

  assign wb_way_o   = wb_valid_o ? way_onehot  : '0;
  assign wb_index_o = wb_valid_o ? index_q     : '0;
  assign wb_tag_o   = wb_valid_o ? evict_tag_q : '0;
  assign flushed_o  = flushed_q;

  evict_way_matches: assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q == RESP && store_res_valid_i && store_res_i.evict)
      |-> (store_res_i.indicator == way_onehot));

`ifdef AXI_LLC_FLUSH_PERF_EN
  logic [31:0] evict_cnt_q, line_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      evict_cnt_q <= '0;
      line_cnt_q  <= '0;
    end else if (accept) begin
      evict_cnt_q <= '0;
      line_cnt_q  <= '0;
    end else begin
      if (wb_valid_o && wb_ready_i && evict_cnt_q != '1) evict_cnt_q <= evict_cnt_q + 32'd1;
      if (store_valid_o && store_ready_i && line_cnt_q != '1) line_cnt_q <= line_cnt_q + 32'd1;
    end
  end

  assign evict_cnt_o = evict_cnt_q;
  assign line_cnt_o  = line_cnt_q;
`endif

endmodule
